// File: rtl/levinson_pkg.sv
// Shared definitions for the sequential reflection-coefficient unit.
// Provides the controller state encoding, format-derived sizing helpers
// and the saturation bit patterns for a W-bit two's-complement k.
package levinson_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Left shift applied to |q| so the integer quotient lands in k's format.
    function automatic int calc_shift(input int unsigned k_frac,
                                      input int unsigned e_frac,
                                      input int unsigned q_frac);
        return int'(k_frac) + int'(e_frac) - int'(q_frac);
    endfunction

    // Number of restoring steps: one per numerator bit.
    function automatic int unsigned calc_iter(input int unsigned w,
                                              input int unsigned shift);
        return w + shift;
    endfunction

    // Largest positive k, as a bit pattern in the low w bits.
    function automatic logic [63:0] k_max_bits(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative k, as a bit pattern in the low w bits.
    function automatic logic [63:0] k_min_bits(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/levinson_divstep.sv
// One combinational radix-2 restoring division step.
// Ports:
//   rem_in  [W-1:0]  partial remainder entering the step (always < divisor)
//   bit_in           next numerator bit, MSB first
//   divisor [W-1:0]  unsigned divisor
//   rem_out [W-1:0]  partial remainder after the step
//   qbit             quotient bit produced by the step
module levinson_divstep #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         qbit
);

    logic [W:0] w_trial;

    // Trial remainder needs one extra bit; the result always fits back in W.
    always_comb begin
        w_trial = {rem_in, bit_in};
        qbit    = (w_trial >= {1'b0, divisor});
        rem_out = qbit ? W'(w_trial - {1'b0, divisor}) : W'(w_trial);
    end

endmodule

// File: rtl/levinson_k_seq.sv
// Sequential reflection-coefficient unit: k = -q/e with a restoring divider.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (in_ready only while idle)
//   e [W-1:0]             unsigned error energy, E_FRAC fractional bits
//   q [W-1:0]             signed correlation term, Q_FRAC fractional bits
//   in_tag [TAG_W-1:0]    tag carried through to out_tag
//   out_valid/out_ready   result handshake, result held under backpressure
//   k [W-1:0]             signed reflection coefficient, K_FRAC fractional bits
//   out_tag [TAG_W-1:0]   tag of the result
//   sat                   result was clipped to K_MAX/K_MIN
//   dz                    e was zero, k forced to 0
module levinson_k_seq
    import levinson_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned E_FRAC = 34,
    parameter int unsigned Q_FRAC = 33,
    parameter int unsigned K_FRAC = 31,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     e,
    input  logic [W-1:0]     q,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     k,
    output logic [TAG_W-1:0] out_tag,
    output logic             sat,
    output logic             dz
);

    localparam int          SHIFT_S = calc_shift(K_FRAC, E_FRAC, Q_FRAC);
    localparam int unsigned SHIFT   = (SHIFT_S < 0) ? 0 : SHIFT_S;
    localparam int unsigned ITER    = calc_iter(W, SHIFT);
    localparam int unsigned CNT_W   = $clog2(ITER + 1);

    localparam logic [W-1:0]    K_MAX   = W'(k_max_bits(W));
    localparam logic [W-1:0]    K_MIN   = W'(k_min_bits(W));
    // Quotient magnitude limits for the negative and positive result ranges.
    localparam logic [ITER-1:0] LIM_NEG = ITER'(1) << (W - 1);
    localparam logic [ITER-1:0] LIM_POS = LIM_NEG - ITER'(1);

    if (SHIFT_S < 0) begin : g_bad_format
        $error("levinson_k_seq: K_FRAC + E_FRAC - Q_FRAC must not be negative");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_step;
    logic               w_fin;
    logic               w_release;

    logic [ITER-1:0]    r_nq;       // numerator shifts out MSB, quotient shifts in LSB
    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_e;
    logic               r_sign;
    logic [TAG_W-1:0]   r_tag;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [W-1:0]       r_k;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_sat;
    logic               r_dz;

    logic [W-1:0]       w_abs_q;
    logic [W-1:0]       w_rem_nxt;
    logic               w_qbit;
    logic [W-1:0]       w_k_res;
    logic               w_sat_res;
    logic               w_dz_res;

    // |q|: the most negative value maps to 2^(W-1), which still fits unsigned.
    assign w_abs_q = q[W-1] ? W'(-q) : q;

    levinson_divstep #(.W(W)) u_divstep (
        .rem_in  (r_rem),
        .bit_in  (r_nq[ITER-1]),
        .divisor (r_e),
        .rem_out (w_rem_nxt),
        .qbit    (w_qbit)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_fin       = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                if (r_cnt == CNT_W'(ITER)) begin
                    w_state_nxt = FIN;
                end else begin
                    w_step = 1'b1;
                end
            end
            FIN: begin
                w_fin       = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sign application, saturation and divide-by-zero override on the quotient.
    always_comb begin
        w_k_res   = '0;
        w_sat_res = 1'b0;
        w_dz_res  = (r_e == '0);
        if (w_dz_res) begin
            w_k_res = '0;
        end else if (!r_sign) begin
            if (r_nq > LIM_NEG) begin
                w_k_res   = K_MIN;
                w_sat_res = 1'b1;
            end else begin
                w_k_res = W'(-r_nq[W-1:0]);
            end
        end else begin
            if (r_nq > LIM_POS) begin
                w_k_res   = K_MAX;
                w_sat_res = 1'b1;
            end else begin
                w_k_res = r_nq[W-1:0];
            end
        end
    end

    // Operand capture and iterative divide.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_nq   <= ITER'(w_abs_q) << SHIFT;
            r_rem  <= '0;
            r_e    <= e;
            r_sign <= q[W-1];
            r_tag  <= in_tag;
            r_cnt  <= '0;
        end else if (w_step) begin
            r_nq  <= {r_nq[ITER-2:0], w_qbit};
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_k         <= '0;
            r_out_tag   <= '0;
            r_sat       <= 1'b0;
            r_dz        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in_ready <= 1'b0;
            end
            if (w_fin) begin
                r_out_valid <= 1'b1;
                r_k         <= w_k_res;
                r_out_tag   <= r_tag;
                r_sat       <= w_sat_res;
                r_dz        <= w_dz_res;
            end
            if (w_release) begin
                r_out_valid <= 1'b0;
                r_in_ready  <= 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign k         = r_k;
    assign out_tag   = r_out_tag;
    assign sat       = r_sat;
    assign dz        = r_dz;

endmodule

// File: tb/tb_levinson_k_seq.sv
// Self-checking bench for levinson_k_seq with default formats.
module tb_levinson_k_seq;

    localparam int unsigned W        = 32;
    localparam int unsigned TAG_W    = 4;
    localparam int          SHIFT_TB = 31 + 34 - 33;
    localparam int          LAT      = 66;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     e;
    logic [W-1:0]     q;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     k;
    logic [TAG_W-1:0] out_tag;
    logic             sat;
    logic             dz;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    levinson_k_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e         (e),
        .q         (q),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .k         (k),
        .out_tag   (out_tag),
        .sat       (sat),
        .dz        (dz)
    );

    // Directed vectors: e, q, expected k, sat, dz.
    logic [31:0] dv_e [8] = '{32'h8000_0000, 32'h0000_0003, 32'h0000_0003, 32'h8000_0000,
                              32'h4000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    logic [31:0] dv_q [8] = '{32'h1000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h4000_0000,
                              32'h4000_0000, 32'hC000_0000, 32'h1234_5678, 32'h0000_0000};
    logic [31:0] dv_k [8] = '{32'hE000_0000, 32'hAAAA_AAAB, 32'h5555_5555, 32'h8000_0000,
                              32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    logic        dv_s [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        dv_z [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reference: exact rational -q*2^SHIFT/e truncated toward zero, then clamped.
    function automatic void ref_k(input logic [31:0] ev, input logic [31:0] qv,
                                  output logic [31:0] kx, output logic sx, output logic dx);
        logic signed [127:0] num, den, quo, hi, lo;
        hi = 128'sd2147483647;
        lo = -hi - 128'sd1;
        kx = '0;
        sx = 1'b0;
        dx = 1'b0;
        if (ev == 32'd0) begin
            dx = 1'b1;
            return;
        end
        num = {{96{qv[31]}}, qv};
        num = -num;
        num = num <<< SHIFT_TB;
        den = {96'd0, ev};
        quo = num / den;
        if (quo > hi) begin
            kx = 32'h7FFF_FFFF;
            sx = 1'b1;
        end else if (quo < lo) begin
            kx = 32'h8000_0000;
            sx = 1'b1;
        end else begin
            kx = quo[31:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set; returns after the accepting edge.
    task automatic start_op(input logic [31:0] ev, input logic [31:0] qv,
                            input logic [3:0] tv, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (in_ready) begin
            ok = 1'b1;
            e        = ev;
            q        = qv;
            in_tag   = tv;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
    endtask

    // Count edges until out_valid is seen, bounded.
    task automatic wait_result(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 300) begin
            tick();
            lat++;
            if (out_valid) ok = 1'b1;
        end
    endtask

    task automatic finish_hs();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        e = '0; q = '0; in_tag = '0;
        tick();
        tick();
        n_vec += 6;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (k !== 32'd0) begin n_err++; $display("FAIL reset_k: got %h want 0", k); end
        if (out_tag !== 4'd0) begin n_err++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        if (sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b want 0", sat); end
        if (dz !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b want 0", dz); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        bit ok, ok2;
        int lat;
        for (int i = 0; i < 8; i++) begin
            start_op(dv_e[i], dv_q[i], 4'(i), ok);
            wait_result(lat, ok2);
            n_vec++;
            if (!(ok && ok2)) begin
                n_err++;
                $display("FAIL dir%0d_timeout: got no result want result", i);
                continue;
            end
            n_vec += 5;
            if (k !== dv_k[i]) begin n_err++; $display("FAIL dir%0d_k: got %h want %h", i, k, dv_k[i]); end
            if (sat !== dv_s[i]) begin n_err++; $display("FAIL dir%0d_sat: got %b want %b", i, sat, dv_s[i]); end
            if (dz !== dv_z[i]) begin n_err++; $display("FAIL dir%0d_dz: got %b want %b", i, dz, dv_z[i]); end
            if (out_tag !== 4'(i)) begin n_err++; $display("FAIL dir%0d_tag: got %h want %h", i, out_tag, 4'(i)); end
            if (lat != LAT) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
            finish_hs();
            n_vec++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_release: got in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        bit ok, ok2;
        int lat;
        logic [31:0] ev, qv, kx;
        logic [3:0]  tv;
        logic        sx, dx;
        for (int i = 0; i < 24; i++) begin
            ev = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) ev = '0;
            qv = 32'($signed($urandom) >>> $urandom_range(0, 31));
            tv = 4'($urandom);
            ref_k(ev, qv, kx, sx, dx);
            start_op(ev, qv, tv, ok);
            wait_result(lat, ok2);
            n_vec++;
            if (!(ok && ok2)) begin
                n_err++;
                $display("FAIL rnd%0d_timeout: got no result want result", i);
                continue;
            end
            n_vec += 4;
            if (k !== kx) begin n_err++; $display("FAIL rnd%0d_k: e=%h q=%h got %h want %h", i, ev, qv, k, kx); end
            if (sat !== sx) begin n_err++; $display("FAIL rnd%0d_sat: e=%h q=%h got %b want %b", i, ev, qv, sat, sx); end
            if (dz !== dx) begin n_err++; $display("FAIL rnd%0d_dz: got %b want %b", i, dz, dx); end
            if (out_tag !== tv) begin n_err++; $display("FAIL rnd%0d_tag: got %h want %h", i, out_tag, tv); end
            finish_hs();
        end
    endtask

    task automatic test_backpressure();
        bit ok, ok2;
        int lat;
        logic [31:0] qv, kx;
        logic        sx, dx;
        qv = $urandom;
        ref_k(32'h1000_0000, qv, kx, sx, dx);
        start_op(32'h1000_0000, qv, 4'h6, ok);
        wait_result(lat, ok2);
        n_vec++;
        if (!(ok && ok2)) begin
            n_err++;
            $display("FAIL bp_timeout: got no result want result");
            return;
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_vec += 4;
            if (k !== kx) begin n_err++; $display("FAIL bp_k_c%0d: got %h want %h", c, k, kx); end
            if (out_tag !== 4'h6) begin n_err++; $display("FAIL bp_tag_c%0d: got %h want 6", c, out_tag); end
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready); end
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid_c%0d: got %b want 1", c, out_valid); end
        end
        finish_hs();
    endtask

    task automatic test_ignore_during_div();
        bit ok, ok2, seen;
        int lat;
        logic [31:0] ev, qv, kx;
        logic        sx, dx;
        ev = 32'h2345_6789;
        qv = 32'hF123_4567;
        ref_k(ev, qv, kx, sx, dx);
        start_op(ev, qv, 4'hA, ok);
        repeat (10) tick();
        e = 32'h0000_0001; q = 32'h7FFF_FFFF; in_tag = 4'h5; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL ign_in_ready_c%0d: got %b want 0", c, in_ready); end
        end
        in_valid = 1'b0;
        wait_result(lat, ok2);
        n_vec++;
        if (!(ok && ok2)) begin
            n_err++;
            $display("FAIL ign_timeout: got no result want result");
            return;
        end
        n_vec += 3;
        if (k !== kx) begin n_err++; $display("FAIL ign_k: got %h want %h", k, kx); end
        if (out_tag !== 4'hA) begin n_err++; $display("FAIL ign_tag: got %h want a", out_tag); end
        if (lat + 15 != LAT) begin n_err++; $display("FAIL ign_latency: got %0d want %0d", lat + 15, LAT); end
        finish_hs();
        seen = 1'b0;
        repeat (80) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL ign_phantom: got out_valid=1 want 0"); end
    endtask

    task automatic test_reset_mid();
        bit ok, ok2, seen;
        int lat;
        start_op(32'h0100_0000, 32'h0200_0000, 4'h3, ok);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec += 2;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_discard: got out_valid=1 want 0"); end
        start_op(32'h0000_0003, 32'hFFFF_FFFF, 4'h9, ok);
        wait_result(lat, ok2);
        n_vec++;
        if (!(ok && ok2)) begin
            n_err++;
            $display("FAIL rstmid_fresh_timeout: got no result want result");
            return;
        end
        n_vec += 4;
        if (k !== 32'h5555_5555) begin n_err++; $display("FAIL rstmid_fresh_k: got %h want 55555555", k); end
        if (sat !== 1'b0) begin n_err++; $display("FAIL rstmid_fresh_sat: got %b want 0", sat); end
        if (out_tag !== 4'h9) begin n_err++; $display("FAIL rstmid_fresh_tag: got %h want 9", out_tag); end
        if (lat != LAT) begin n_err++; $display("FAIL rstmid_fresh_latency: got %0d want %0d", lat, LAT); end
        finish_hs();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_ignore_during_div();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
